// File: rtl/bp_pkg.sv
// Types shared by the BTB and the branch resolve unit: the prediction record and
// the resolve FSM states.
package bp_pkg;
    localparam int BP_ADDR_WIDTH  = 24;
    localparam int BP_INSTR_BYTES = 4;

    typedef struct packed {
        logic [BP_ADDR_WIDTH-1:0] pc;
        logic                     hit;
        logic [BP_ADDR_WIDTH-1:0] target;
    } pred_entry_t;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_RECOVER = 1'b1
    } bru_state_t;
endpackage

// File: rtl/branch_resolve_unit_if.sv
// Fetch prediction, execute resolution, BTB update and fetch redirect signals.
// The slave side is the resolve unit.
interface branch_resolve_unit_if #(
    parameter int ADDR_WIDTH = 24
);
    logic                  pred_valid;
    logic [ADDR_WIDTH-1:0] pred_pc;
    logic                  pred_hit;
    logic [ADDR_WIDTH-1:0] pred_target;
    logic                  pred_ready;
    logic                  res_valid;
    logic                  res_taken;
    logic [ADDR_WIDTH-1:0] res_target;
    logic                  upd_valid;
    logic [ADDR_WIDTH-1:0] upd_pc;
    logic [ADDR_WIDTH-1:0] upd_target;
    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_pc;

    modport slave (
        input  pred_valid, pred_pc, pred_hit, pred_target,
        input  res_valid, res_taken, res_target,
        output pred_ready, upd_valid, upd_pc, upd_target,
        output redirect_valid, redirect_pc
    );

    modport master (
        output pred_valid, pred_pc, pred_hit, pred_target,
        output res_valid, res_taken, res_target,
        input  pred_ready, upd_valid, upd_pc, upd_target,
        input  redirect_valid, redirect_pc
    );
endinterface

// File: rtl/bp_pred_fifo.sv
// In-order queue of fetch-time predictions awaiting resolution; flush beats push.
module bp_pred_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic        pop,
    input  logic        flush,
    input  pred_entry_t wr_entry,
    output pred_entry_t rd_entry,
    output logic [PTR_W:0] count
);
    pred_entry_t      mem_q [DEPTH];
    pred_entry_t      mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = wr_entry;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
        end
    end

    // Storage carries no reset; only the pointers and occupancy define validity.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rd_entry = mem_q[rd_ptr_q];
    assign count    = count_q;
endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves queued fetch predictions against execute outcomes and produces the BTB
// update write, the fetch redirect on mispredict, and resolve statistics.
module branch_resolve_unit
    import bp_pkg::*;
#(
    parameter int ADDR_WIDTH  = BP_ADDR_WIDTH,
    parameter int DEPTH       = 4,
    parameter int INSTR_BYTES = BP_INSTR_BYTES,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    branch_resolve_unit_if.slave bus,
    output logic                 underflow_err,
    output logic [CNT_WIDTH-1:0] stat_branches,
    output logic [CNT_WIDTH-1:0] stat_mispredicts
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]        FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] PC_INC   = ADDR_WIDTH'(INSTR_BYTES);

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    bru_state_t            state_q, state_d;
    logic                  upd_valid_q, upd_valid_d;
    logic [ADDR_WIDTH-1:0] upd_pc_q, upd_pc_d;
    logic [ADDR_WIDTH-1:0] upd_target_q, upd_target_d;
    logic                  redirect_valid_q, redirect_valid_d;
    logic [ADDR_WIDTH-1:0] redirect_pc_q, redirect_pc_d;
    logic                  underflow_q, underflow_d;
    logic [CNT_WIDTH-1:0]  branches_q, branches_d;
    logic [CNT_WIDTH-1:0]  mispredicts_q, mispredicts_d;

    pred_entry_t    wr_entry, head;
    logic [PTR_W:0] count;
    logic           in_run, pred_ready, push, pop, tgt_match, mispredict, flush;

    assign in_run     = (state_q == ST_RUN);
    assign pred_ready = in_run && (count < FULL_CNT);
    assign push       = bus.pred_valid && pred_ready;
    // Resolutions are only accepted in RUN; the RECOVER cycle discards them.
    assign pop        = in_run && bus.res_valid && (count != '0);
    assign tgt_match  = (head.target == bus.res_target);
    assign mispredict = (head.hit != bus.res_taken) || (head.hit && bus.res_taken && !tgt_match);
    assign flush      = pop && mispredict;

    always_comb begin
        wr_entry        = '0;
        wr_entry.pc     = bus.pred_pc;
        wr_entry.hit    = bus.pred_hit;
        wr_entry.target = bus.pred_target;
    end

    bp_pred_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .flush    (flush),
        .wr_entry (wr_entry),
        .rd_entry (head),
        .count    (count)
    );

    always_comb begin
        state_d          = flush ? ST_RECOVER : ST_RUN;
        upd_valid_d      = 1'b0;
        upd_pc_d         = upd_pc_q;
        upd_target_d     = upd_target_q;
        redirect_valid_d = flush;
        redirect_pc_d    = redirect_pc_q;
        underflow_d      = underflow_q | (in_run && bus.res_valid && (count == '0));
        branches_d       = branches_q;
        mispredicts_d    = mispredicts_q;
        if (pop) begin
            branches_d = sat_inc(branches_q);
            if (bus.res_taken && !(head.hit && tgt_match)) begin
                upd_valid_d  = 1'b1;
                upd_pc_d     = head.pc;
                upd_target_d = bus.res_target;
            end
        end
        if (flush) begin
            mispredicts_d = sat_inc(mispredicts_q);
            redirect_pc_d = bus.res_taken ? bus.res_target : head.pc + PC_INC;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_RUN;
            upd_valid_q      <= 1'b0;
            upd_pc_q         <= '0;
            upd_target_q     <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            underflow_q      <= 1'b0;
            branches_q       <= '0;
            mispredicts_q    <= '0;
        end else begin
            state_q          <= state_d;
            upd_valid_q      <= upd_valid_d;
            upd_pc_q         <= upd_pc_d;
            upd_target_q     <= upd_target_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            underflow_q      <= underflow_d;
            branches_q       <= branches_d;
            mispredicts_q    <= mispredicts_d;
        end
    end

    assign bus.pred_ready     = pred_ready;
    assign bus.upd_valid      = upd_valid_q;
    assign bus.upd_pc         = upd_pc_q;
    assign bus.upd_target     = upd_target_q;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign underflow_err      = underflow_q;
    assign stat_branches      = branches_q;
    assign stat_mispredicts   = mispredicts_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: table of single-branch vectors plus hand-written
// multi-cycle sequences, with a scoreboard queue for the registered update/redirect.
module tb_branch_resolve_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        uf_main, uf_small;
    logic [15:0] br_main, mp_main;
    logic [3:0]  br_small, mp_small;

    branch_resolve_unit_if #(.ADDR_WIDTH(24)) bus ();
    branch_resolve_unit_if #(.ADDR_WIDTH(24)) bus_s ();

    branch_resolve_unit #(.ADDR_WIDTH(24), .DEPTH(4), .INSTR_BYTES(4), .CNT_WIDTH(16)) dut (
        .clk              (clk),
        .reset            (reset),
        .bus              (bus),
        .underflow_err    (uf_main),
        .stat_branches    (br_main),
        .stat_mispredicts (mp_main)
    );

    // Narrow-counter instance so saturation is reachable in a few dozen cycles.
    branch_resolve_unit #(.ADDR_WIDTH(24), .DEPTH(4), .INSTR_BYTES(4), .CNT_WIDTH(4)) dut_s (
        .clk              (clk),
        .reset            (reset),
        .bus              (bus_s),
        .underflow_err    (uf_small),
        .stat_branches    (br_small),
        .stat_mispredicts (mp_small)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] pc;   logic hit;   logic [23:0] tgt;
        logic taken;       logic [23:0] rtgt;
        logic e_uv;        logic [23:0] e_upc;  logic [23:0] e_utgt;
        logic e_rv;        logic [23:0] e_rpc;
        int   e_br;        int   e_mp;
    } vec_t;

    typedef struct {
        logic uv; logic [23:0] upc; logic [23:0] utgt; logic rv; logic [23:0] rpc;
    } exp_t;

    vec_t vecs [7];
    exp_t exp_q [$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic uv, input logic [23:0] upc, input logic [23:0] utgt,
                            input logic rv, input logic [23:0] rpc);
        exp_t e;
        e.uv = uv; e.upc = upc; e.utgt = utgt; e.rv = rv; e.rpc = rpc;
        exp_q.push_back(e);
    endtask

    task automatic sb_check(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            chk({tag, " scoreboard_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, " upd_valid"},      {31'd0, bus.upd_valid},      {31'd0, e.uv});
            chk({tag, " upd_pc"},         {8'd0, bus.upd_pc},          {8'd0, e.upc});
            chk({tag, " upd_target"},     {8'd0, bus.upd_target},      {8'd0, e.utgt});
            chk({tag, " redirect_valid"}, {31'd0, bus.redirect_valid}, {31'd0, e.rv});
            if (e.rv) chk({tag, " redirect_pc"}, {8'd0, bus.redirect_pc}, {8'd0, e.rpc});
        end
    endtask

    task automatic chk_stats(input string tag, input int br, input int mp);
        chk({tag, " stat_branches"},    {16'd0, br_main}, br);
        chk({tag, " stat_mispredicts"}, {16'd0, mp_main}, mp);
    endtask

    initial begin
        //        pc         hit tgt        tk rtgt       uv upc        utgt       rv rpc        br mp
        vecs[0] = '{24'h000100, 1, 24'h000200, 1, 24'h000200, 0, 24'h000000, 24'h000000, 0, 24'h0, 1, 0};
        vecs[1] = '{24'h000100, 0, 24'h000000, 1, 24'h000300, 1, 24'h000100, 24'h000300, 1, 24'h000300, 2, 1};
        vecs[2] = '{24'hFFFFFC, 1, 24'h000010, 0, 24'h000000, 0, 24'h000100, 24'h000300, 1, 24'h000000, 3, 2};
        vecs[3] = '{24'h000400, 1, 24'h000500, 1, 24'h000600, 1, 24'h000400, 24'h000600, 1, 24'h000600, 4, 3};
        vecs[4] = '{24'h000800, 0, 24'h000000, 0, 24'h000000, 0, 24'h000400, 24'h000600, 0, 24'h0, 5, 3};
        vecs[5] = '{24'h000900, 0, 24'h001234, 0, 24'h000ABC, 0, 24'h000400, 24'h000600, 0, 24'h0, 6, 3};
        vecs[6] = '{24'h000A00, 1, 24'h000B00, 1, 24'h000B00, 0, 24'h000400, 24'h000600, 0, 24'h0, 7, 3};

        bus.pred_valid = 0; bus.pred_pc = '0; bus.pred_hit = 0; bus.pred_target = '0;
        bus.res_valid = 0;  bus.res_taken = 0; bus.res_target = '0;
        bus_s.pred_valid = 0; bus_s.pred_pc = '0; bus_s.pred_hit = 0; bus_s.pred_target = '0;
        bus_s.res_valid = 0;  bus_s.res_taken = 0; bus_s.res_target = '0;

        step(); step();
        reset = 0;
        chk("rst upd_valid",      {31'd0, bus.upd_valid},      32'd0);
        chk("rst upd_pc",         {8'd0, bus.upd_pc},          32'd0);
        chk("rst redirect_valid", {31'd0, bus.redirect_valid}, 32'd0);
        chk("rst redirect_pc",    {8'd0, bus.redirect_pc},     32'd0);
        chk("rst underflow_err",  {31'd0, uf_main},            32'd0);
        chk("rst pred_ready",     {31'd0, bus.pred_ready},     32'd1);
        chk_stats("rst", 0, 0);

        for (int i = 0; i < 7; i++) begin
            bus.pred_valid = 1; bus.pred_pc = vecs[i].pc;
            bus.pred_hit = vecs[i].hit; bus.pred_target = vecs[i].tgt;
            step();
            bus.pred_valid = 0;
            bus.res_valid = 1; bus.res_taken = vecs[i].taken; bus.res_target = vecs[i].rtgt;
            push_exp(vecs[i].e_uv, vecs[i].e_upc, vecs[i].e_utgt, vecs[i].e_rv, vecs[i].e_rpc);
            step();
            bus.res_valid = 0;
            sb_check($sformatf("vec%0d", i));
            chk_stats($sformatf("vec%0d", i), vecs[i].e_br, vecs[i].e_mp);
            if (vecs[i].e_rv) begin
                chk($sformatf("vec%0d recover pred_ready", i), {31'd0, bus.pred_ready}, 32'd0);
                step();
                chk($sformatf("vec%0d run pred_ready", i), {31'd0, bus.pred_ready}, 32'd1);
                chk($sformatf("vec%0d redirect one-shot", i), {31'd0, bus.redirect_valid}, 32'd0);
            end
        end

        // Fill the queue, then mispredict the oldest; res_valid in RECOVER is ignored.
        for (int k = 0; k < 4; k++) begin
            bus.pred_valid = 1; bus.pred_pc = 24'h001000 + 24'(4 * k); bus.pred_hit = 0;
            bus.pred_target = '0;
            step();
        end
        bus.pred_valid = 0;
        chk("full pred_ready", {31'd0, bus.pred_ready}, 32'd0);
        bus.res_valid = 1; bus.res_taken = 1; bus.res_target = 24'h002000;
        push_exp(1, 24'h001000, 24'h002000, 1, 24'h002000);
        step();
        bus.res_taken = 0;
        sb_check("fill");
        chk("fill recover pred_ready", {31'd0, bus.pred_ready}, 32'd0);
        chk_stats("fill", 8, 4);
        step();
        bus.res_valid = 0;
        chk("recover ignores res underflow", {31'd0, uf_main}, 32'd0);
        chk_stats("recover ignores res", 8, 4);
        chk("after recover pred_ready", {31'd0, bus.pred_ready}, 32'd1);
        chk("after recover redirect", {31'd0, bus.redirect_valid}, 32'd0);

        // In-order resolution with a simultaneous enqueue and dequeue.
        bus.pred_valid = 1; bus.pred_pc = 24'h003000; bus.pred_hit = 0;
        step();
        bus.pred_pc = 24'h003004;
        bus.res_valid = 1; bus.res_taken = 0; bus.res_target = 24'h00DEAD;
        push_exp(0, 24'h001000, 24'h002000, 0, 24'h0);
        step();
        bus.pred_valid = 0;
        sb_check("order0");
        bus.res_taken = 1; bus.res_target = 24'h005000;
        push_exp(1, 24'h003004, 24'h005000, 1, 24'h005000);
        step();
        bus.res_valid = 0;
        sb_check("order1");
        chk_stats("order", 10, 5);
        step();

        // A same-cycle enqueue during a mispredict is dropped with the flush.
        bus.pred_valid = 1; bus.pred_pc = 24'h006000; bus.pred_hit = 1; bus.pred_target = 24'h007000;
        step();
        bus.pred_pc = 24'h006100; bus.pred_target = 24'h007100;
        bus.res_valid = 1; bus.res_taken = 0; bus.res_target = '0;
        push_exp(0, 24'h003004, 24'h005000, 1, 24'h006004);
        step();
        bus.pred_valid = 0; bus.res_valid = 0;
        sb_check("drop");
        chk_stats("drop", 11, 6);
        step();
        bus.res_valid = 1; bus.res_taken = 1; bus.res_target = 24'h00BEEF;
        step();
        bus.res_valid = 0;
        chk("underflow set", {31'd0, uf_main}, 32'd1);
        chk_stats("underflow", 11, 6);
        chk("underflow no upd", {31'd0, bus.upd_valid}, 32'd0);
        chk("underflow no redirect", {31'd0, bus.redirect_valid}, 32'd0);
        step(); step(); step();
        chk("underflow sticky", {31'd0, uf_main}, 32'd1);

        // Reset during a mispredicting resolve suppresses the pulses and flushes.
        bus.pred_valid = 1; bus.pred_pc = 24'h008000; bus.pred_hit = 0;
        step();
        bus.pred_valid = 0;
        reset = 1; bus.res_valid = 1; bus.res_taken = 1; bus.res_target = 24'h009000;
        step();
        reset = 0; bus.res_valid = 0;
        chk("midrst upd_valid",      {31'd0, bus.upd_valid},      32'd0);
        chk("midrst upd_pc",         {8'd0, bus.upd_pc},          32'd0);
        chk("midrst redirect_valid", {31'd0, bus.redirect_valid}, 32'd0);
        chk("midrst underflow_err",  {31'd0, uf_main},            32'd0);
        chk("midrst pred_ready",     {31'd0, bus.pred_ready},     32'd1);
        chk_stats("midrst", 0, 0);
        bus.res_valid = 1;
        step();
        bus.res_valid = 0;
        chk("midrst queue flushed", {31'd0, uf_main}, 32'd1);
        chk_stats("midrst post", 0, 0);

        // Saturation on the 4-bit counter instance: every resolve mispredicts.
        for (int k = 0; k < 18; k++) begin
            bus_s.pred_valid = 1; bus_s.pred_pc = 24'(16 * k); bus_s.pred_hit = 0;
            step();
            bus_s.pred_valid = 0;
            bus_s.res_valid = 1; bus_s.res_taken = 1; bus_s.res_target = 24'h000040;
            step();
            bus_s.res_valid = 0;
            step();
            if (k == 13) chk("sat mispredicts 14", {28'd0, mp_small}, 32'hE);
        end
        chk("sat stat_mispredicts", {28'd0, mp_small}, 32'hF);
        chk("sat stat_branches",    {28'd0, br_small}, 32'hF);
        chk("sat redirect_pc",      {8'd0, bus_s.redirect_pc}, 32'h40);

        chk("scoreboard drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
